// File: rtl/cpu_ctr_pkg.sv
// rtl/cpu_ctr_pkg.sv - state, opcode/func, ALU and mux encodings for the multicycle control unit
`timescale 1ns/1ps

package cpu_ctr_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REGA   = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    // Instruction-class summary handed from the decoder to the FSM.
    typedef struct packed {
        logic       is_valid;
        logic       is_j;
        logic       is_jal;
        logic       is_jr;
        logic       is_shift;
        logic       is_imm;
        logic       is_sext;
        logic       is_lw;
        logic       is_sw;
        logic       is_beq;
        logic       is_bne;
        logic [3:0] aluc;
    } iclass_t;

    function automatic logic branch_taken(input logic is_beq, input logic is_bne,
                                          input logic zero);
        return (is_beq & zero) | (is_bne & ~zero);
    endfunction

endpackage

// File: rtl/cpu_ctr_decode.sv
// rtl/cpu_ctr_decode.sv - combinational op/func decode into instruction classes
// Shift funcs decoded only when CPUCTR_SHIFT_EN is defined.
`timescale 1ns/1ps

module cpu_ctr_decode
    import cpu_ctr_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    cls
);

    logic rtype;
    logic r_add, r_sub, r_and, r_or, r_xor, r_jr;
    logic r_sll, r_srl, r_sra;
    logic i_addi, i_andi, i_ori, i_xori, i_lui;

    always_comb begin
        rtype  = (op == OP_RTYPE);
        r_add  = rtype && (func == FN_ADD);
        r_sub  = rtype && (func == FN_SUB);
        r_and  = rtype && (func == FN_AND);
        r_or   = rtype && (func == FN_OR);
        r_xor  = rtype && (func == FN_XOR);
        r_jr   = rtype && (func == FN_JR);
`ifdef CPUCTR_SHIFT_EN
        r_sll  = rtype && (func == FN_SLL);
        r_srl  = rtype && (func == FN_SRL);
        r_sra  = rtype && (func == FN_SRA);
`else
        r_sll  = 1'b0;
        r_srl  = 1'b0;
        r_sra  = 1'b0;
`endif
        i_addi = (op == OP_ADDI);
        i_andi = (op == OP_ANDI);
        i_ori  = (op == OP_ORI);
        i_xori = (op == OP_XORI);
        i_lui  = (op == OP_LUI);

        cls          = '0;
        cls.is_j     = (op == OP_J);
        cls.is_jal   = (op == OP_JAL);
        cls.is_jr    = r_jr;
        cls.is_lw    = (op == OP_LW);
        cls.is_sw    = (op == OP_SW);
        cls.is_beq   = (op == OP_BEQ);
        cls.is_bne   = (op == OP_BNE);
        cls.is_shift = r_sll | r_srl | r_sra;
        cls.is_imm   = i_addi | i_andi | i_ori | i_xori | i_lui;
        cls.is_sext  = i_addi | cls.is_lw | cls.is_sw | cls.is_beq | cls.is_bne;
        cls.is_valid = r_add | r_sub | r_and | r_or | r_xor | r_jr | cls.is_shift |
                       cls.is_imm | cls.is_j | cls.is_jal | cls.is_lw | cls.is_sw |
                       cls.is_beq | cls.is_bne;

        // Address arithmetic (lw/sw) falls through to the add default.
        if (r_sub | cls.is_beq | cls.is_bne) cls.aluc = ALUC_SUB;
        else if (r_and | i_andi)             cls.aluc = ALUC_AND;
        else if (r_or | i_ori)               cls.aluc = ALUC_OR;
        else if (r_xor | i_xori)             cls.aluc = ALUC_XOR;
        else if (i_lui)                      cls.aluc = ALUC_LUI;
        else if (r_sll)                      cls.aluc = ALUC_SLL;
        else if (r_srl)                      cls.aluc = ALUC_SRL;
        else if (r_sra)                      cls.aluc = ALUC_SRA;
        else                                 cls.aluc = ALUC_ADD;
    end

endmodule

// File: rtl/cpu_ctr.sv
// rtl/cpu_ctr.sv - multicycle MIPS-subset control FSM (IF/ID/EXE/MEM/WB), Mealy outputs
// Optional shift decode enabled by CPUCTR_SHIFT_EN.
`timescale 1ns/1ps

module cpu_ctr
    import cpu_ctr_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       jal,
    output logic       m2reg,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [1:0] pcsource,
    output logic [3:0] aluc,
    output logic [2:0] state
);

    state_t  cur;
    iclass_t cls;
    logic    is_jump;
    logic    is_mem;
    logic    is_branch;
    logic    taken;

    cpu_ctr_decode u_decode (
        .op   (op),
        .func (func),
        .cls  (cls)
    );

    assign is_jump   = cls.is_j | cls.is_jal | cls.is_jr;
    assign is_mem    = cls.is_lw | cls.is_sw;
    assign is_branch = cls.is_beq | cls.is_bne;
    assign taken     = branch_taken(cls.is_beq, cls.is_bne, zero);
    assign state     = cur;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cur <= S_IF;
        end else begin
            unique case (cur)
                S_IF:  cur <= S_ID;
                // Jumps finish here; undefined encodings also retire here as a nop.
                S_ID:  cur <= (is_jump || !cls.is_valid) ? S_IF : S_EXE;
                S_EXE: begin
                    if (is_branch)   cur <= S_IF;
                    else if (is_mem) cur <= S_MEM;
                    else             cur <= S_WB;
                end
                S_MEM: cur <= cls.is_lw ? S_WB : S_IF;
                S_WB:  cur <= S_IF;
                default: cur <= S_IF;
            endcase
        end
    end

    // Outputs follow state and the live op/func/zero; all held low while in reset.
    always_comb begin
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        jal      = 1'b0;
        m2reg    = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REG;
        sext     = 1'b0;
        pcsource = PC_ALU;
        aluc     = ALUC_ADD;
        if (clrn) begin
            unique case (cur)
                S_IF: begin
                    wpc     = 1'b1;
                    wir     = 1'b1;
                    alusrcb = SRCB_FOUR;
                end
                S_ID: begin
                    if (cls.is_jr) begin
                        wpc      = 1'b1;
                        pcsource = PC_REGA;
                    end else if (cls.is_j || cls.is_jal) begin
                        wpc      = 1'b1;
                        pcsource = PC_JUMP;
                        wreg     = cls.is_jal;
                        jal      = cls.is_jal;
                    end else if (cls.is_valid) begin
                        // Branch target computed speculatively for every non-jump.
                        alusrcb  = SRCB_BR;
                        sext     = 1'b1;
                    end
                end
                S_EXE: begin
                    alusrca = 1'b1;
                    shift   = cls.is_shift;
                    alusrcb = (cls.is_imm || is_mem) ? SRCB_IMM : SRCB_REG;
                    sext    = cls.is_sext;
                    aluc    = cls.aluc;
                    if (is_branch && taken) begin
                        wpc      = 1'b1;
                        pcsource = PC_BRANCH;
                    end
                end
                S_MEM: begin
                    iord = 1'b1;
                    wmem = cls.is_sw;
                end
                S_WB: begin
                    wreg  = 1'b1;
                    regrt = cls.is_imm | cls.is_lw;
                    m2reg = cls.is_lw;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctr.sv
// tb/tb_cpu_ctr.sv - self-checking bench for cpu_ctr against a per-instruction cycle-sequence model
`timescale 1ns/1ps

module tb_cpu_ctr;

    typedef struct packed {
        logic       wpc, wir, wmem, wreg, iord, regrt, jal, m2reg, shift, alusrca;
        logic [1:0] alusrcb;
        logic       sext;
        logic [1:0] pcsource;
        logic [3:0] aluc;
        logic [2:0] state;
    } vec_t;

    logic       clk;
    logic       clrn;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       wpc, wir, wmem, wreg, iord, regrt, jal, m2reg, shift, alusrca, sext;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;
    logic [2:0] state;
    vec_t       act;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];

    cpu_ctr dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .zero(zero),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
        .regrt(regrt), .jal(jal), .m2reg(m2reg), .shift(shift),
        .alusrca(alusrca), .alusrcb(alusrcb), .sext(sext),
        .pcsource(pcsource), .aluc(aluc), .state(state)
    );

    assign act = {wpc, wir, wmem, wreg, iord, regrt, jal, m2reg, shift, alusrca,
                  alusrcb, sext, pcsource, aluc, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string mnem(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: begin
                case (f)
                    6'b100000: return "add";
                    6'b100010: return "sub";
                    6'b100100: return "and";
                    6'b100101: return "or";
                    6'b100110: return "xor";
                    6'b001000: return "jr";
`ifdef CPUCTR_SHIFT_EN
                    6'b000000: return "sll";
                    6'b000010: return "srl";
                    6'b000011: return "sra";
`endif
                    default:   return "nop";
                endcase
            end
            6'b001000: return "addi";
            6'b001100: return "andi";
            6'b001101: return "ori";
            6'b001110: return "xori";
            6'b100011: return "lw";
            6'b101011: return "sw";
            6'b000100: return "beq";
            6'b000101: return "bne";
            6'b001111: return "lui";
            6'b000010: return "j";
            6'b000011: return "jal";
            default:   return "nop";
        endcase
    endfunction

    function automatic logic [3:0] aluc_of(input string m);
        if (m == "sub" || m == "beq" || m == "bne") return 4'b0100;
        if (m == "and" || m == "andi")              return 4'b0001;
        if (m == "or"  || m == "ori")               return 4'b0101;
        if (m == "xor" || m == "xori")              return 4'b0010;
        if (m == "lui")                             return 4'b0110;
        if (m == "sll")                             return 4'b0011;
        if (m == "srl")                             return 4'b0111;
        if (m == "sra")                             return 4'b1111;
        return 4'b0000;
    endfunction

    // Expected per-cycle control vectors for one instruction, IF first.
    task automatic build_expect(input logic [5:0] o, input logic [5:0] f, input logic z);
        vec_t  v;
        string m;
        logic  imm, shf, tk;
        m   = mnem(o, f);
        imm = (m == "addi" || m == "andi" || m == "ori" || m == "xori" || m == "lui");
        shf = (m == "sll" || m == "srl" || m == "sra");
        exp_q.delete();
        v = '0; v.wpc = 1; v.wir = 1; v.alusrcb = 2'b01; v.state = 3'd0;
        exp_q.push_back(v);
        v = '0; v.state = 3'd1;
        if (m == "nop") begin
            exp_q.push_back(v);
            return;
        end
        if (m == "j" || m == "jal" || m == "jr") begin
            v.wpc = 1;
            v.pcsource = (m == "jr") ? 2'b10 : 2'b11;
            v.wreg = (m == "jal");
            v.jal  = (m == "jal");
            exp_q.push_back(v);
            return;
        end
        v.alusrcb = 2'b11; v.sext = 1;
        exp_q.push_back(v);
        v = '0; v.state = 3'd2; v.alusrca = 1; v.shift = shf;
        v.alusrcb = (imm || m == "lw" || m == "sw") ? 2'b10 : 2'b00;
        v.sext = (m == "addi" || m == "lw" || m == "sw" || m == "beq" || m == "bne");
        v.aluc = aluc_of(m);
        if (m == "beq" || m == "bne") begin
            tk = (m == "beq") ? z : !z;
            v.wpc = tk;
            v.pcsource = tk ? 2'b01 : 2'b00;
            exp_q.push_back(v);
            return;
        end
        exp_q.push_back(v);
        if (m == "lw" || m == "sw") begin
            v = '0; v.state = 3'd3; v.iord = 1; v.wmem = (m == "sw");
            exp_q.push_back(v);
            if (m == "sw") return;
        end
        v = '0; v.state = 3'd4; v.wreg = 1; v.regrt = imm || (m == "lw"); v.m2reg = (m == "lw");
        exp_q.push_back(v);
    endtask

    // Entered just after a rising edge with the DUT in IF; leaves it the same way.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input string tag);
        build_expect(o, f, z);
        op = o; func = f; zero = z;
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (act !== exp_q[i]) begin
                errors++;
                $display("FAIL %s op=%b func=%b zero=%b cycle %0d: got %h expected %h",
                         tag, o, f, z, i, act, exp_q[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; op = 6'b111111; func = 6'b111111; zero = 1'b0;
        #0.5;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", act);
        end
        #0.5 clrn = 1'b1;
        #1;
        checks++;
        if (state !== 3'b000 || wpc !== 1'b1 || wir !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_if: state=%b wpc=%b wir=%b expected 000 1 1", state, wpc, wir);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (state !== 3'b000) begin
            errors++;
            $display("FAIL reset_nop_return: state=%b expected 000", state);
        end
    endtask

    task automatic test_directed();
        run_instr(6'b000000, 6'b100000, 1'b0, "add");
        run_instr(6'b100011, 6'b010101, 1'b0, "lw");
        run_instr(6'b101011, 6'b000000, 1'b1, "sw");
        run_instr(6'b000100, 6'b000000, 1'b1, "beq_taken");
        run_instr(6'b000100, 6'b000000, 1'b0, "beq_not_taken");
        run_instr(6'b000101, 6'b000000, 1'b1, "bne_not_taken");
        run_instr(6'b000101, 6'b000000, 1'b0, "bne_taken");
        run_instr(6'b000011, 6'b000000, 1'b0, "jal");
        run_instr(6'b000000, 6'b001000, 1'b0, "jr");
        run_instr(6'b001111, 6'b000000, 1'b0, "lui");
        run_instr(6'b000000, 6'b000000, 1'b0, "op0_func0");
        run_instr(6'b000000, 6'b000011, 1'b0, "sra_slot");
        run_instr(6'b111111, 6'b111111, 1'b0, "undefined");
    endtask

    task automatic test_latency();
        logic [5:0] ops[7]  = '{6'b000010, 6'b000000, 6'b000011, 6'b000100,
                                6'b000000, 6'b101011, 6'b100011};
        logic [5:0] fns[7]  = '{6'b0, 6'b001000, 6'b0, 6'b0, 6'b100010, 6'b0, 6'b0};
        int         lat[7]  = '{2, 2, 2, 3, 4, 4, 5};
        for (int k = 0; k < 7; k++) begin
            int n;
            op = ops[k]; func = fns[k]; zero = 1'b0;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (state !== 3'b000 && n < 20);
            checks++;
            if (n !== lat[k]) begin
                errors++;
                $display("FAIL latency op=%b func=%b: got %0d expected %0d", ops[k], fns[k], n, lat[k]);
            end
        end
    endtask

    task automatic test_abort();
        op = 6'b100011; func = 6'b0; zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (state !== 3'b010) begin
            errors++;
            $display("FAIL abort_reach_exe: state=%b expected 010", state);
        end
        clrn = 1'b0;
        #1;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %h expected 0", act);
        end
        @(posedge clk); #1;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL abort_held: got %h expected 0", act);
        end
        op = 6'b111111; func = 6'b111111;
        @(negedge clk); #1 clrn = 1'b1;
        #1;
        checks++;
        if (state !== 3'b000 || wpc !== 1'b1 || wir !== 1'b1 || wmem !== 1'b0 || wreg !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart_if: state=%b wpc=%b wir=%b wmem=%b wreg=%b expected 000 1 1 0 0",
                     state, wpc, wir, wmem, wreg);
        end
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [11:0] defs[21] = '{
            {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
            {6'b000000, 6'b100101}, {6'b000000, 6'b100110}, {6'b000000, 6'b001000},
            {6'b000000, 6'b000000}, {6'b000000, 6'b000010}, {6'b000000, 6'b000011},
            {6'b001000, 6'b000000}, {6'b001100, 6'b000000}, {6'b001101, 6'b000000},
            {6'b001110, 6'b000000}, {6'b100011, 6'b000000}, {6'b101011, 6'b000000},
            {6'b000100, 6'b000000}, {6'b000101, 6'b000000}, {6'b001111, 6'b000000},
            {6'b000010, 6'b000000}, {6'b000011, 6'b000000}, {6'b000000, 6'b111111}};
        for (int k = 0; k < 200; k++) begin
            logic [11:0] pick;
            if ($urandom_range(0, 9) < 8) begin
                pick = defs[$urandom_range(0, 20)];
                if (pick[11:6] != 6'b000000) pick[5:0] = 6'($urandom);
            end else begin
                pick = 12'($urandom);
            end
            run_instr(pick[11:6], pick[5:0], 1'($urandom), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
